// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
// Shared types and helpers for the parametrised sequential multiplier.
//   state_e    : control FSM states (IDLE, RUN, DONE)
//   booth_op_e : per-iteration accumulator operation (NOP, ADD, SUB)
//   clog2()    : ceiling log2, used to size the iteration counter
// Optional feature macro used by the multiplier files: MULT_SIGNED_EN
// ---------------------------------------------------------------------------
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        NOP,
        ADD,
        SUB
    } booth_op_e;

    // Number of bits needed to hold values 0..value-1.
    // Callers pass WIDTH+1 so the counter can hold WIDTH itself.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mult_step.sv
// ---------------------------------------------------------------------------
// mult_step
// One combinational shift-add (or radix-2 Booth) multiplier iteration.
// Ports:
//   acc_i    [WIDTH:0]   running partial product (high half, one guard bit)
//   q_i      [WIDTH-1:0] multiplier / low product bits
//   q_m1_i               Booth history bit
//   m_i      [WIDTH-1:0] multiplicand
//   signed_i             1 = Booth signed iteration (only with MULT_SIGNED_EN)
//   acc_o, q_o, q_m1_o   values after the add/sub and the one-bit right shift
// Macro MULT_SIGNED_EN: when undefined, signed_i is ignored and no subtractor
// is built.
// ---------------------------------------------------------------------------
module mult_step
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   acc_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic             q_m1_i,
    input  logic [WIDTH-1:0] m_i,
    input  logic             signed_i,
    output logic [WIDTH:0]   acc_o,
    output logic [WIDTH-1:0] q_o,
    output logic             q_m1_o
);

    booth_op_e      op;
    logic [WIDTH:0] m_ext;
    logic [WIDTH:0] acc_sum;
    logic           shift_in;

`ifndef MULT_SIGNED_EN
    logic [1:0] unused_inputs;
    assign unused_inputs = {signed_i, q_m1_i};
`endif

    always_comb begin
        op       = NOP;
        m_ext    = {1'b0, m_i};
        shift_in = 1'b0;
        acc_sum  = acc_i;

`ifdef MULT_SIGNED_EN
        if (signed_i) begin
            // Booth recoding on the current bit and the one shifted out last
            m_ext    = {m_i[WIDTH-1], m_i};
            unique case ({q_i[0], q_m1_i})
                2'b01:   op = ADD;
                2'b10:   op = SUB;
                default: op = NOP;
            endcase
        end else begin
            op = q_i[0] ? ADD : NOP;
        end
`else
        op = q_i[0] ? ADD : NOP;
`endif

        case (op)
            ADD:     acc_sum = acc_i + m_ext;
`ifdef MULT_SIGNED_EN
            SUB:     acc_sum = acc_i - m_ext;
`endif
            default: acc_sum = acc_i;
        endcase

`ifdef MULT_SIGNED_EN
        // Arithmetic shift keeps the sign of the guard-extended accumulator
        shift_in = signed_i ? acc_sum[WIDTH] : 1'b0;
`endif

        // Right shift of {acc, q, q_m1}: the bit leaving q becomes q_m1
        {acc_o, q_o, q_m1_o} = {shift_in, acc_sum, q_i};
    end

endmodule

// File: rtl/seq_multiplier_param.sv
// ---------------------------------------------------------------------------
// seq_multiplier_param
// Sequential WIDTH x WIDTH -> 2*WIDTH multiplier, one iteration per cycle.
// Ports:
//   clock, reset_b            rising-edge clock, async active-low reset
//   start                     request, accepted on an edge while ready=1
//   signed_mode               two's-complement operands (MULT_SIGNED_EN only)
//   multiplicand, multiplier  operands, latched on the accepting edge
//   product   [2W-1:0]        registered result, held until next completion
//   ready                     high while idle
//   done                      one-cycle pulse when a new product appears
// Macro MULT_SIGNED_EN enables Booth signed operation; when undefined every
// operation is unsigned and signed_mode is ignored.
// ---------------------------------------------------------------------------
module seq_multiplier_param
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clock,
    input  logic               reset_b,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic [2*WIDTH-1:0] product,
    output logic               ready,
    output logic               done
);

    localparam int CNT_W = clog2(WIDTH + 1);

    state_e             state_q, state_d;
    logic [WIDTH:0]     acc_q, acc_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               q_m1_q, q_m1_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               signed_q, signed_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               done_q, done_d;

    logic [WIDTH:0]     step_acc;
    logic [WIDTH-1:0]   step_q;
    logic               step_q_m1;

    mult_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc_i    (acc_q),
        .q_i      (q_q),
        .q_m1_i   (q_m1_q),
        .m_i      (m_q),
        .signed_i (signed_q),
        .acc_o    (step_acc),
        .q_o      (step_q),
        .q_m1_o   (step_q_m1)
    );

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            q_q       <= '0;
            q_m1_q    <= 1'b0;
            m_q       <= '0;
            cnt_q     <= '0;
            signed_q  <= 1'b0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            q_m1_q    <= q_m1_d;
            m_q       <= m_d;
            cnt_q     <= cnt_d;
            signed_q  <= signed_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        q_d       = q_q;
        q_m1_d    = q_m1_q;
        m_d       = m_q;
        cnt_d     = cnt_q;
        signed_d  = signed_q;
        product_d = product_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    acc_d    = '0;
                    q_d      = multiplier;
                    q_m1_d   = 1'b0;
                    m_d      = multiplicand;
                    cnt_d    = CNT_W'(WIDTH);
                    signed_d = signed_mode;
                end
            end
            RUN: begin
                acc_d  = step_acc;
                q_d    = step_q;
                q_m1_d = step_q_m1;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // The guard bit of acc is dropped; the product fits in 2W bits
                product_d = {acc_q[WIDTH-1:0], q_q};
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign product = product_q;
    assign done    = done_q;
    assign ready   = (state_q == IDLE);

endmodule
